// File: rtl/stall_unit_if.sv
// stall_unit_if: D-stage operand/producer info and flush in; stall and md_busy out.
interface stall_unit_if;
    logic       flush;
    logic [4:0] D_rs, D_rt, D_dst;
    logic [2:0] D_Tuse_rs, D_Tuse_rt;
    logic [1:0] D_Tnew;
    logic       D_md_start, D_md_div, D_md_use;
    logic       stall, md_busy;

    modport master (
        output flush, D_rs, D_rt, D_dst, D_Tuse_rs, D_Tuse_rt, D_Tnew,
               D_md_start, D_md_div, D_md_use,
        input  stall, md_busy
    );
    modport slave (
        input  flush, D_rs, D_rt, D_dst, D_Tuse_rs, D_Tuse_rt, D_Tnew,
               D_md_start, D_md_div, D_md_use,
        output stall, md_busy
    );
endinterface

// File: rtl/stall_unit.sv
// stall_unit: Tuse/Tnew hazard scoreboard (E/M slots) driving a pipeline stall.
// STALL_UNIT_MD_EN enables the HI/LO busy counter; otherwise md_busy is tied low.
module stall_unit (
    input  logic         clk,
    input  logic         reset,
    stall_unit_if.slave  bus
);
    logic [4:0] e_dst, m_dst;
    logic [1:0] e_tnew, m_tnew;
    logic       rs_hazard, rt_hazard, md_hazard, md_busy, stall, issue;

    always_comb begin
        rs_hazard = bus.D_Tuse_rs != 3'b111 && bus.D_rs != 5'd0 &&
                    ((bus.D_rs == e_dst && {1'b0, e_tnew} > bus.D_Tuse_rs) ||
                     (bus.D_rs == m_dst && {1'b0, m_tnew} > bus.D_Tuse_rs));
        rt_hazard = bus.D_Tuse_rt != 3'b111 && bus.D_rt != 5'd0 &&
                    ((bus.D_rt == e_dst && {1'b0, e_tnew} > bus.D_Tuse_rt) ||
                     (bus.D_rt == m_dst && {1'b0, m_tnew} > bus.D_Tuse_rt));
    end

    assign stall       = rs_hazard | rt_hazard | md_hazard;
    assign issue       = !stall && !bus.flush;
    assign bus.stall   = stall;
    assign bus.md_busy = md_busy;

    // W needs no slot: a producer leaving M always has tnew 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_dst  <= 5'd0;
            e_tnew <= 2'd0;
            m_dst  <= 5'd0;
            m_tnew <= 2'd0;
        end else begin
            e_dst  <= issue ? bus.D_dst : 5'd0;
            e_tnew <= issue ? bus.D_Tnew : 2'd0;
            m_dst  <= bus.flush ? 5'd0 : e_dst;
            m_tnew <= bus.flush ? 2'd0 : (e_tnew == 2'd0 ? 2'd0 : e_tnew - 2'd1);
        end
    end

`ifdef STALL_UNIT_MD_EN
    logic [3:0] md_cnt;

    // flush does not touch the count: an issued HI/LO operation runs to completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            md_cnt <= 4'd0;
        else if (issue && bus.D_md_start)
            md_cnt <= bus.D_md_div ? 4'd10 : 4'd5;
        else if (md_cnt != 4'd0)
            md_cnt <= md_cnt - 4'd1;
    end

    assign md_busy   = md_cnt != 4'd0;
    assign md_hazard = bus.D_md_use & md_busy;
`else
    logic unused_md;
    assign unused_md = ^{bus.D_md_start, bus.D_md_div, bus.D_md_use};
    assign md_busy   = 1'b0;
    assign md_hazard = 1'b0;
`endif
endmodule

// File: tb/tb_stall_unit.sv
// tb_stall_unit: directed vectors; expectations queued by the driver, checked by a negedge monitor.
module tb_stall_unit;
`ifdef STALL_UNIT_MD_EN
    localparam logic MD = 1'b1;
`else
    localparam logic MD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stall_unit_if bus();
    stall_unit dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        string name;
        logic  stall;
        logic  busy;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (bus.stall !== e.stall || bus.md_busy !== e.busy) begin
                n_err++;
                $display("FAIL %s: got stall=%b md_busy=%b, expected stall=%b md_busy=%b",
                         e.name, bus.stall, bus.md_busy, e.stall, e.busy);
            end
        end
    end

    task automatic quiet();
        bus.flush = 1'b0;
        bus.D_rs = 5'd0;
        bus.D_rt = 5'd0;
        bus.D_Tuse_rs = 3'b111;
        bus.D_Tuse_rt = 3'b111;
        bus.D_dst = 5'd0;
        bus.D_Tnew = 2'd0;
        bus.D_md_start = 1'b0;
        bus.D_md_div = 1'b0;
        bus.D_md_use = 1'b0;
    endtask

    task automatic producer(input logic [4:0] d, input logic [1:0] t);
        quiet();
        bus.D_dst = d;
        bus.D_Tnew = t;
    endtask

    task automatic consumer(input logic [4:0] rs, input logic [2:0] urs,
                            input logic [4:0] rt, input logic [2:0] urt);
        quiet();
        bus.D_rs = rs;
        bus.D_Tuse_rs = urs;
        bus.D_rt = rt;
        bus.D_Tuse_rt = urt;
    endtask

    task automatic md(input logic start, input logic div, input logic use_md);
        quiet();
        bus.D_md_start = start;
        bus.D_md_div = div;
        bus.D_md_use = use_md;
    endtask

    // queue the expectation for the current inputs, then advance one cycle
    task automatic cyc(input string name, input logic s, input logic b);
        exp_t e;
        e.name = name;
        e.stall = s;
        e.busy = b;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        quiet();
        @(posedge clk);
        #1;
        cyc("in_reset", 1'b0, 1'b0);
        reset = 1'b0;

        // load-use: one stall, then issue
        producer(5'd8, 2'd2);           cyc("lu_lw", 1'b0, 1'b0);
        consumer(5'd8, 3'd1, 5'd0, 3'd7); cyc("lu_stall", 1'b1, 1'b0);
        bus.D_dst = 5'd9; bus.D_Tnew = 2'd1; cyc("lu_issue", 1'b0, 1'b0);
        quiet();                        cyc("lu_quiet", 1'b0, 1'b0);

        // load-branch: two stalls
        producer(5'd8, 2'd2);           cyc("lb_lw", 1'b0, 1'b0);
        consumer(5'd8, 3'd0, 5'd0, 3'd7); cyc("lb_stall1", 1'b1, 1'b0);
        cyc("lb_stall2", 1'b1, 1'b0);
        cyc("lb_issue", 1'b0, 1'b0);

        // rt path through the M slot
        producer(5'd10, 2'd2);          cyc("rt_lw", 1'b0, 1'b0);
        consumer(5'd3, 3'd0, 5'd10, 3'd1); cyc("rt_stall", 1'b1, 1'b0);
        cyc("rt_issue", 1'b0, 1'b0);

        // $0 and unused operands
        producer(5'd0, 2'd2);           cyc("zero_prod", 1'b0, 1'b0);
        consumer(5'd0, 3'd0, 5'd0, 3'd7); cyc("zero_cons", 1'b0, 1'b0);
        producer(5'd12, 2'd2);          cyc("unused_lw", 1'b0, 1'b0);
        consumer(5'd0, 3'd7, 5'd12, 3'd7); cyc("rt_unused", 1'b0, 1'b0);
        consumer(5'd0, 3'd7, 5'd12, 3'd0); cyc("m_tnew1", 1'b1, 1'b0);
        cyc("m_tnew0", 1'b0, 1'b0);
        producer(5'd31, 2'd0);          cyc("jal", 1'b0, 1'b0);
        consumer(5'd31, 3'd0, 5'd0, 3'd7); cyc("jal_use", 1'b0, 1'b0);

        // flush clears E and M
        producer(5'd8, 2'd2);           cyc("fl_lw", 1'b0, 1'b0);
        consumer(5'd8, 3'd0, 5'd0, 3'd7); bus.flush = 1'b1; cyc("fl_stall", 1'b1, 1'b0);
        consumer(5'd8, 3'd0, 5'd0, 3'd7); cyc("fl_cleared", 1'b0, 1'b0);
        producer(5'd8, 2'd2); bus.flush = 1'b1; cyc("fl_prio", 1'b0, 1'b0);
        consumer(5'd8, 3'd0, 5'd0, 3'd7); cyc("fl_not_issued", 1'b0, 1'b0);

        // div busy; a stalled mult must not reload the counter
        md(1'b1, 1'b1, 1'b1);           cyc("div_issue", 1'b0, 1'b0);
        md(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc("div_busy", MD, MD);
        cyc("mult_issue", 1'b0, 1'b0);
        md(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc("mult_busy", MD, MD);
        cyc("mult_done", 1'b0, 1'b0);

        // flush at count 7 lets the count continue
        md(1'b1, 1'b1, 1'b0);           cyc("div2_issue", 1'b0, 1'b0);
        quiet();
        for (int i = 0; i < 3; i++) cyc("div2_run", 1'b0, MD);
        bus.flush = 1'b1;               cyc("flush_cnt7", 1'b0, MD);
        quiet();
        for (int i = 0; i < 6; i++) cyc("after_flush", 1'b0, MD);
        cyc("md_drain", 1'b0, 1'b0);

        // asynchronous reset mid-divide at count 4, with lw in E
        md(1'b1, 1'b1, 1'b0);           cyc("div3_issue", 1'b0, 1'b0);
        quiet();
        for (int i = 0; i < 5; i++) cyc("div3_run", 1'b0, MD);
        producer(5'd8, 2'd2);           cyc("lw_cnt5", 1'b0, MD);
        reset = 1'b1;
        consumer(5'd8, 3'd0, 5'd0, 3'd7); bus.D_md_use = 1'b1;
        cyc("reset_async", 1'b0, 1'b0);
        reset = 1'b0;
        cyc("post_reset", 1'b0, 1'b0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
